// File: rtl/array_pkg.sv
//============================================================================
// Module   : array_pkg
// Desc     : Shared types and constants for the array_2p dual-port array.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package array_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 8;

endpackage

`default_nettype wire

// File: rtl/array_clear_seq.sv
//============================================================================
// Module   : array_clear_seq
// Desc     : Clear sequencer; sweeps CLEAR_VAL through every word after
//            reset and on clr_req, and reports busy while doing so.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module array_clear_seq #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 16,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic [DATA_W-1:0] clr_data
);
    import array_pkg::*;

    localparam logic [ADDR_W-1:0] c_ptr_last = '1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        clr_we      = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                // Sweep is frozen while rst is held so the pointer stays at 0.
                clr_we    = ~rst;
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == c_ptr_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    assign busy     = rst | (r_state == ST_CLEAR);
    assign clr_addr = r_ptr;
    assign clr_data = CLEAR_VAL;

endmodule

`default_nettype wire

// File: rtl/array_2p.sv
//============================================================================
// Module   : array_2p
// Desc     : Parametrised simple-dual-port array with RD_LAT 1/2 read
//            pipeline and a built-in clear sequencer.
// Options  : ARRAY_2P_WR_BYPASS_EN - same-index read/write returns new data
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module array_2p #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 8,
    parameter int                RD_LAT    = 1,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_index,
    input  logic [DATA_W-1:0] wr_val,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_index,
    output logic [DATA_W-1:0] rd_val,
    output logic              rd_valid
);
    import array_pkg::*;

    localparam int c_depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [c_depth];

    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic [DATA_W-1:0] w_clr_data;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_rd_acc;
    logic [DATA_W-1:0] w_rd_word;

    array_clear_seq #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .CLEAR_VAL (CLEAR_VAL)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr),
        .clr_data (w_clr_data)
    );

    // The clear sweep owns the write port whenever it is active.
    assign w_we     = w_clr_we | (wr_en & ~busy);
    assign w_waddr  = w_clr_we ? w_clr_addr : wr_index;
    assign w_wdata  = w_clr_we ? w_clr_data : wr_val;
    assign w_rd_acc = rd_en & ~busy;

    always_ff @(posedge clk) begin
        if (w_we) begin
            mem[w_waddr] <= w_wdata;
        end
    end

`ifdef ARRAY_2P_WR_BYPASS_EN
    assign w_rd_word = (w_we && (w_waddr == rd_index)) ? w_wdata : mem[rd_index];
`else
    assign w_rd_word = mem[rd_index];
`endif

    generate
        if (RD_LAT >= RD_LAT_MAX) begin : g_lat2
            logic              r_v1;
            logic [DATA_W-1:0] r_d1;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v1     <= 1'b0;
                    r_d1     <= '0;
                    rd_valid <= 1'b0;
                    rd_val   <= '0;
                end else begin
                    r_v1     <= w_rd_acc;
                    rd_valid <= r_v1;
                    if (w_rd_acc) begin
                        r_d1 <= w_rd_word;
                    end
                    if (r_v1) begin
                        rd_val <= r_d1;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_valid <= 1'b0;
                    rd_val   <= '0;
                end else begin
                    rd_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        rd_val <= w_rd_word;
                    end
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_array_2p.sv
//============================================================================
// Module   : tb_array_2p
// Desc     : Directed self-checking bench; drives an RD_LAT=1 and an
//            RD_LAT=2 instance of array_2p from the same stimulus.
// Options  : ARRAY_2P_WR_BYPASS_EN selects the collision expectation
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_array_2p;

    logic        clk;
    logic        rst;
    logic        clr_req;
    logic        wr_en;
    logic [7:0]  wr_index;
    logic [15:0] wr_val;
    logic        rd_en;
    logic [7:0]  rd_index;

    logic        busy1;
    logic [15:0] rd_val1;
    logic        rd_valid1;
    logic        busy2;
    logic [15:0] rd_val2;
    logic        rd_valid2;

    int checks   = 0;
    int failures = 0;

`ifdef ARRAY_2P_WR_BYPASS_EN
    localparam logic [15:0] c_coll_exp = 16'h2222;
`else
    localparam logic [15:0] c_coll_exp = 16'h1111;
`endif

    array_2p #(.DATA_W(16), .ADDR_W(8), .RD_LAT(1), .CLEAR_VAL(16'h0000)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (busy1),
        .wr_en    (wr_en),
        .wr_index (wr_index),
        .wr_val   (wr_val),
        .rd_en    (rd_en),
        .rd_index (rd_index),
        .rd_val   (rd_val1),
        .rd_valid (rd_valid1)
    );

    array_2p #(.DATA_W(16), .ADDR_W(8), .RD_LAT(2), .CLEAR_VAL(16'h0000)) u_dut2 (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (busy2),
        .wr_en    (wr_en),
        .wr_index (wr_index),
        .wr_val   (wr_val),
        .rd_en    (rd_en),
        .rd_index (rd_index),
        .rd_val   (rd_val2),
        .rd_valid (rd_valid2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_busy(input string tag, input int exp_cycles);
        int cnt;
        cnt = 0;
        while (busy1 && cnt < 400) begin
            tick();
            cnt++;
        end
        chk(tag, cnt, exp_cycles);
        chk({tag, "_busy2"}, busy2, 1'b0);
    endtask

    task automatic do_write(input logic [7:0] idx, input logic [15:0] val);
        wr_en    = 1'b1;
        wr_index = idx;
        wr_val   = val;
        tick();
        wr_en    = 1'b0;
    endtask

    task automatic read1(input string tag, input logic [7:0] idx, input logic [15:0] exp);
        rd_en    = 1'b1;
        rd_index = idx;
        tick();
        rd_en    = 1'b0;
        chk({tag, "_valid"}, rd_valid1, 1'b1);
        chk({tag, "_val"}, rd_val1, exp);
        tick();
        chk({tag, "_pulse_end"}, rd_valid1, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        clr_req  = 1'b0;
        wr_en    = 1'b0;
        wr_index = '0;
        wr_val   = '0;
        rd_en    = 1'b0;
        rd_index = '0;

        // Reset held for three cycles
        tick();
        chk("rst_busy", busy1, 1'b1);
        chk("rst_valid1", rd_valid1, 1'b0);
        chk("rst_val1", rd_val1, 16'h0000);
        chk("rst_valid2", rd_valid2, 1'b0);
        chk("rst_val2", rd_val2, 16'h0000);
        tick();
        tick();
        rst = 1'b0;
        wait_busy("init_clear_len", 256);

        read1("clr_rd0", 8'd0, 16'h0000);
        read1("clr_rd128", 8'd128, 16'h0000);
        read1("clr_rd255", 8'd255, 16'h0000);

        // Write then read back, value must hold afterwards
        do_write(8'h12, 16'hBEEF);
        read1("wr_rd", 8'h12, 16'hBEEF);
        chk("wr_rd_hold", rd_val1, 16'hBEEF);

        // Same-index collision
        do_write(8'h40, 16'h1111);
        wr_en    = 1'b1;
        wr_index = 8'h40;
        wr_val   = 16'h2222;
        rd_en    = 1'b1;
        rd_index = 8'h40;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("coll_valid", rd_valid1, 1'b1);
        chk("coll_val", rd_val1, c_coll_exp);
        tick();
        read1("coll_after", 8'h40, 16'h2222);

        // Pipelined reads through the RD_LAT=2 instance
        do_write(8'd1, 16'hA001);
        do_write(8'd2, 16'hA002);
        do_write(8'd3, 16'hA003);
        do_write(8'd4, 16'hA004);
        rd_en    = 1'b1;
        rd_index = 8'd1;
        tick();
        chk("pipe_v2_early", rd_valid2, 1'b0);
        chk("pipe_l1_d1", rd_val1, 16'hA001);
        rd_index = 8'd2;
        tick();
        chk("pipe_v2_c1", rd_valid2, 1'b1);
        chk("pipe_d2_c1", rd_val2, 16'hA001);
        rd_index = 8'd3;
        tick();
        chk("pipe_v2_c2", rd_valid2, 1'b1);
        chk("pipe_d2_c2", rd_val2, 16'hA002);
        rd_index = 8'd4;
        tick();
        chk("pipe_v2_c3", rd_valid2, 1'b1);
        chk("pipe_d2_c3", rd_val2, 16'hA003);
        chk("pipe_l1_d4", rd_val1, 16'hA004);
        rd_en = 1'b0;
        tick();
        chk("pipe_v2_c4", rd_valid2, 1'b1);
        chk("pipe_d2_c4", rd_val2, 16'hA004);
        tick();
        chk("pipe_v2_end", rd_valid2, 1'b0);
        chk("pipe_d2_hold", rd_val2, 16'hA004);

        // clr_req alongside a read of pre-clear data
        do_write(8'd5, 16'h5555);
        rd_en    = 1'b1;
        rd_index = 8'd5;
        clr_req  = 1'b1;
        tick();
        rd_en   = 1'b0;
        clr_req = 1'b0;
        chk("clrreq_valid", rd_valid1, 1'b1);
        chk("clrreq_val", rd_val1, 16'h5555);
        chk("clrreq_busy", busy1, 1'b1);
        wr_en    = 1'b1;
        wr_index = 8'd200;
        wr_val   = 16'hDEAD;
        rd_en    = 1'b1;
        rd_index = 8'd5;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("busy_rd_dropped", rd_valid1, 1'b0);
        wait_busy("clrreq_len", 255);
        read1("clrreq_rd5", 8'd5, 16'h0000);
        read1("clrreq_rd200", 8'd200, 16'h0000);

        // Reset at clear pointer 100
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (100) tick();
        chk("midclr_busy", busy1, 1'b1);
        rst   = 1'b1;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        rst   = 1'b0;
        chk("midclr_valid1", rd_valid1, 1'b0);
        wait_busy("midclr_len", 256);

        // Reset while a read is in flight
        do_write(8'h33, 16'h7777);
        rd_en    = 1'b1;
        rd_index = 8'h33;
        tick();
        rd_en = 1'b0;
        chk("flight_l1_val", rd_val1, 16'h7777);
        chk("flight_v2_pending", rd_valid2, 1'b0);
        rst = 1'b1;
        tick();
        chk("flight_v1", rd_valid1, 1'b0);
        chk("flight_d1", rd_val1, 16'h0000);
        chk("flight_v2", rd_valid2, 1'b0);
        chk("flight_d2", rd_val2, 16'h0000);
        rst = 1'b0;
        tick();
        chk("flight_v2_late", rd_valid2, 1'b0);
        wait_busy("flight_len", 255);
        read1("flight_rd33", 8'h33, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/array_2p.md
Name: array_2p

Overview:
- Parametrised simple-dual-port successor to the team's 256x16 single-port array.
- Independent write and read ports, so a write and a read can happen in the same cycle.
- Configurable read latency with a read-valid strobe.
- Built-in clear sequencer: fills every word with CLEAR_VAL after reset and on request.
- Used as line/pixel scratch storage in the pixel pipeline, wherever the old array could not read and write together.

Parameters:
- DATA_W, 16, word width in bits.
- ADDR_W, 8, index width; DEPTH = 2**ADDR_W words (localparam; never out of range).
- RD_LAT, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register).
- CLEAR_VAL, 0, DATA_W-bit value written to every word by the clear sequencer.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- clr_req  in  1  single-cycle request to re-clear the whole array.
- busy  out  1  high while in reset or clearing; user port requests are ignored.
- wr_en  in  1  write strobe.
- wr_index  in  ADDR_W  write address.
- wr_val  in  DATA_W  write data.
- rd_en  in  1  read strobe.
- rd_index  in  ADDR_W  read address.
- rd_val  out  DATA_W  read data; holds its last value between reads.
- rd_valid  out  1  one-cycle pulse, RD_LAT cycles after an accepted rd_en.

Behaviour:
- Reset values: busy=1, rd_val=0, rd_valid=0, all pipeline valids=0, clear pointer=0, FSM=CLEAR.
- Memory contents are not reset directly; they are overwritten by the clear sequence.
- FSM state CLEAR:
  - While rst=1 the pointer holds at 0 and no writes occur.
  - After rst falls, each cycle writes CLEAR_VAL to mem[ptr] and increments ptr.
  - When the write to ptr=DEPTH-1 occurs, go to IDLE next cycle.
  - busy falls exactly DEPTH cycles after rst deasserts (DEPTH=256 gives 256 cycles).
- FSM state IDLE:
  - busy=0; user writes and reads are accepted.
  - clr_req=1 moves to CLEAR with ptr=0; busy=1 from the next cycle.
  - The first clear write happens in the cycle after the request. A wr_en in the request cycle is still performed.
- clr_req while in CLEAR or during rst: ignored; the sweep is not restarted.
- rst asserted mid-clear or mid-read:
  - Returns to CLEAR with ptr=0.
  - Flushes all pending rd_valid; rd_val goes to 0.
  - The full sweep repeats after release.
- While busy=1: wr_en and rd_en are dropped (not queued); rd_valid is never generated for them.
- Write: with wr_en=1 and busy=0, mem[wr_index] <= wr_val at the clock edge.
- Read, RD_LAT=1: rd_en at edge N gives rd_val=mem[rd_index] and rd_valid=1 after edge N+1.
- Read, RD_LAT=2: same, but one cycle later through the output register.
- Reads accepted before a clr_req complete normally; they return pre-clear data.
- Back-to-back reads: one per cycle, fully pipelined; rd_valid is asserted continuously.
- Simultaneous read and write to different addresses: independent.
- Simultaneous read and write to the same address: governed by the optional feature below.

Optional Feature:
- Macro ARRAY_2P_WR_BYPASS_EN.
- Defined: a same-cycle read and write to the same index returns the new wr_val (write-first forwarding).
- Undefined: returns the old stored word (read-first). This is the default, and matches block-RAM inference.

Decomposition:
- Shared package array_pkg holds:
  - FSM state typedef (ST_IDLE, ST_CLEAR).
  - Legal RD_LAT constants (RD_LAT_MIN=1, RD_LAT_MAX=2).
  - Default widths (DATA_W_DEF=16, ADDR_W_DEF=8).
- One natural sub-module: array_clear_seq, containing the FSM, pointer and busy generation.
  - It outputs the clear write-enable, address and data.
  - The top level muxes these onto the memory write port ahead of the user port.
- The storage array and read pipeline stay in array_2p.

Test Plan:
- Reset and clear: rst high 3 cycles, then low.
  - busy stays 1 for exactly 256 cycles, then 0.
  - Reading indices 0, 128 and 255 returns 0x0000 with rd_valid 1 cycle (RD_LAT=1) after each rd_en.
- Write then read: write 0xBEEF to index 0x12, read index 0x12 next cycle.
  - rd_val=0xBEEF with one rd_valid pulse; rd_val holds 0xBEEF afterwards.
- Same-address collision: index 0x40 holds 0x1111; in the same cycle write 0x2222 and read 0x40.
  - Returns 0x1111 without the macro, 0x2222 with ARRAY_2P_WR_BYPASS_EN.
  - A later read returns 0x2222 in both builds.
- Pipelined reads at RD_LAT=2: rd_en on 4 consecutive cycles to indices 1 to 4 (preloaded 0xA001 to 0xA004).
  - rd_valid high for 4 consecutive cycles starting 2 cycles after the first rd_en; data in order.
- clr_req with traffic: preload index 5=0x5555, issue a read of 5 and clr_req in the same cycle.
  - Read returns 0x5555; busy rises; writes during busy are dropped.
  - After 256 clear cycles, index 5 reads 0x0000.
- Reset mid-clear: assert rst for 1 cycle at clear ptr=100 while a read is in flight.
  - No rd_valid for the read; rd_val=0.
  - busy lasts a further 256 cycles after rst release.
